// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: queues every non-r0 regfile write and drains it over valid/ready.
// Optional PC storage per entry is built when WB_TRACE_PC_EN is defined.
module wb_trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_ctrl_writeEnable,
  input  logic [4:0]        i_ctrl_writeReg,
  input  logic [31:0]       i_data_writeReg,
  input  logic [11:0]       i_address_imem,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [4:0]        o_reg,
  output logic [31:0]       o_data,
  output logic [11:0]       o_pc,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic [15:0]       o_drop_count
);

`ifdef WB_TRACE_PC_EN
  localparam int unsigned EntryW = 49;
`else
  localparam int unsigned EntryW = 37;
`endif

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CountOne  = (ADDR_W + 1)'(1);

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] head_q, head_d;
  logic [EntryW-1:0] push_entry;
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d, rp_inc;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              push, pop, full, accept, drop, mem_we;

`ifdef WB_TRACE_PC_EN
  assign push_entry = {i_address_imem, i_ctrl_writeReg, i_data_writeReg};
  assign o_pc       = head_q[48:37];
`else
  logic unused_pc;
  assign unused_pc  = ^i_address_imem;
  assign push_entry = {i_ctrl_writeReg, i_data_writeReg};
  assign o_pc       = 12'd0;
`endif

  assign o_reg        = head_q[36:32];
  assign o_data       = head_q[31:0];
  assign o_count      = count_q;
  assign o_full       = (count_q == FullCount);
  assign o_empty      = (count_q == '0);
  assign o_valid      = (count_q != '0);
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_cnt_q;

  always_comb begin
    push       = i_ctrl_writeEnable && (i_ctrl_writeReg != 5'd0);
    pop        = (count_q != '0) && i_ready;
    full       = (count_q == FullCount);
    accept     = push && (!full || pop);
    drop       = push && full && !pop;
    rp_inc     = rp_q + 1'b1;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    head_d     = head_q;
    mem_we     = 1'b0;
    if (i_clear) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      mem_we = accept;
      if (accept) wp_d = wp_q + 1'b1;
      if (pop) rp_d = rp_inc;
      if (accept && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !accept) begin
        count_d = count_q - 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
      end
      // Head register tracks the entry at the post-edge read pointer; holds when empty.
      if (pop) begin
        if (count_q == CountOne) begin
          if (accept) head_d = push_entry;
        end else begin
          head_d = mem_q[rp_inc];
        end
      end else if ((count_q == '0) && accept) begin
        head_d = push_entry;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      head_q     <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) mem_q[wp_q] <= push_entry;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed-vector bench for wb_trace_fifo; PC expectations follow WB_TRACE_PC_EN.
module tb_wb_trace_fifo;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset, i_clear, we, rdy;
  logic [4:0]        wreg;
  logic [31:0]       wdata;
  logic [11:0]       wpc;
  logic              o_valid, o_full, o_empty, o_overflow;
  logic [4:0]        o_reg;
  logic [31:0]       o_data;
  logic [11:0]       o_pc;
  logic [ADDR_W:0]   o_count;
  logic [15:0]       o_drop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  wb_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock              (clock),
    .reset              (reset),
    .i_clear            (i_clear),
    .i_ctrl_writeEnable (we),
    .i_ctrl_writeReg    (wreg),
    .i_data_writeReg    (wdata),
    .i_address_imem     (wpc),
    .o_valid            (o_valid),
    .i_ready            (rdy),
    .o_reg              (o_reg),
    .o_data             (o_data),
    .o_pc               (o_pc),
    .o_count            (o_count),
    .o_full             (o_full),
    .o_empty            (o_empty),
    .o_overflow         (o_overflow),
    .o_drop_count       (o_drop_count)
  );

  typedef struct {
    logic        clr, we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [11:0] wpc;
    logic        rdy;
    logic        e_valid;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [11:0] e_pc;
    logic [4:0]  e_count;
    logic        e_full, e_empty, e_ovf;
    logic [15:0] e_drop;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [11:0] p;
  } ent_t;

  function automatic logic [11:0] pcx(input logic [11:0] p);
`ifdef WB_TRACE_PC_EN
    return p;
`else
    return 12'd0;
`endif
  endfunction

  function automatic ent_t wr_ent(input int k);
    ent_t e;
    e.r = 5'((k % 31) + 1);
    e.d = 32'h1000_0000 + 32'(k);
    e.p = 12'h100 + 12'(k);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [4:0] r, input logic [31:0] d,
                          input logic [11:0] p);
    chk({nm, ".reg"}, 32'(o_reg), 32'(r));
    chk({nm, ".data"}, o_data, d);
    chk({nm, ".pc"}, 32'(o_pc), 32'(pcx(p)));
  endtask

  task automatic chk_stat(input string nm, input logic v, input logic [4:0] c, input logic f,
                          input logic e, input logic ov, input logic [15:0] dc);
    chk({nm, ".valid"}, 32'(o_valid), 32'(v));
    chk({nm, ".count"}, 32'(o_count), 32'(c));
    chk({nm, ".full"}, 32'(o_full), 32'(f));
    chk({nm, ".empty"}, 32'(o_empty), 32'(e));
    chk({nm, ".overflow"}, 32'(o_overflow), 32'(ov));
    chk({nm, ".drops"}, 32'(o_drop_count), 32'(dc));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [4:0] r, input logic [31:0] d,
                       input logic [11:0] p, input logic rd);
    i_clear = c; we = w; wreg = r; wdata = d; wpc = p; rdy = rd;
  endtask

  vec_t vecs[9];
  ent_t exp_q[$];
  ent_t e;

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0, 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    //          clr we  reg    data           pc       rdy  v  reg   data           pc      cnt f e ov drop
    vecs[0] = '{1'b0, 1'b0, 5'd0, 32'd0,        12'h000, 1'b0, 1'b0, 5'd0, 32'd0,        12'h000, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 5'd0, 32'hDEAD,     12'h002, 1'b0, 1'b0, 5'd0, 32'd0,        12'h000, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b1, 5'd1, 32'd65535,    12'h003, 1'b0, 1'b1, 5'd1, 32'd65535,    12'h003, 5'd1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3] = '{1'b0, 1'b1, 5'd2, 32'hFFFFFFFE, 12'h004, 1'b0, 1'b1, 5'd1, 32'd65535,    12'h003, 5'd2, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[4] = '{1'b0, 1'b0, 5'd0, 32'd0,        12'h000, 1'b1, 1'b1, 5'd2, 32'hFFFFFFFE, 12'h004, 5'd1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 32'd0,        12'h000, 1'b1, 1'b0, 5'd2, 32'hFFFFFFFE, 12'h004, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[6] = '{1'b0, 1'b1, 5'd3, 32'd7,        12'h005, 1'b1, 1'b1, 5'd3, 32'd7,        12'h005, 5'd1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[7] = '{1'b0, 1'b1, 5'd4, 32'd8,        12'h006, 1'b1, 1'b1, 5'd4, 32'd8,        12'h006, 5'd1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[8] = '{1'b0, 1'b0, 5'd0, 32'd0,        12'h000, 1'b0, 1'b1, 5'd4, 32'd8,        12'h006, 5'd1, 1'b0, 1'b0, 1'b0, 16'd0};

    // Reset state before any stimulus.
    chk_stat("reset", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    chk_head("reset", 5'd0, 32'd0, 12'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].clr, vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].wpc, vecs[i].rdy);
      step();
      chk_stat($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_count, vecs[i].e_full,
               vecs[i].e_empty, vecs[i].e_ovf, vecs[i].e_drop);
      chk_head($sformatf("vec%0d", i), vecs[i].e_reg, vecs[i].e_data, vecs[i].e_pc);
    end

    // Clear, then DEPTH+3 writes with the sink stalled: three drops.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 12'd0, 1'b0);
    step();
    chk_stat("clr0", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    for (int k = 0; k < DEPTH + 3; k++) begin
      e = wr_ent(k);
      drive(1'b0, 1'b1, e.r, e.d, e.p, 1'b0);
      step();
      if (k < DEPTH) exp_q.push_back(e);
    end
    e = wr_ent(0);
    chk_stat("ovf", 1'b1, 5'(DEPTH), 1'b1, 1'b0, 1'b1, 16'd3);
    chk_head("ovf", e.r, e.d, e.p);

    // Full with simultaneous push and pop.
    e.r = 5'd30; e.d = 32'h0000_AAAA; e.p = 12'h0AB;
    drive(1'b0, 1'b1, e.r, e.d, e.p, 1'b1);
    step();
    void'(exp_q.pop_front());
    exp_q.push_back(e);
    chk_stat("fullpp", 1'b1, 5'(DEPTH), 1'b1, 1'b0, 1'b1, 16'd3);

    drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      chk_head($sformatf("drain%0d", i), e.r, e.d, e.p);
      step();
    end
    chk_stat("drained", 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 16'd3);

    // Clear with the queue full and a push pending.
    for (int k = 0; k < DEPTH; k++) begin
      e = wr_ent(k + 40);
      drive(1'b0, 1'b1, e.r, e.d, e.p, 1'b0);
      step();
    end
    chk_stat("refill", 1'b1, 5'(DEPTH), 1'b1, 1'b0, 1'b1, 16'd3);
    drive(1'b1, 1'b1, 5'd9, 32'h9999, 12'h099, 1'b0);
    step();
    chk_stat("clrpend", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0, 1'b0);
    step();
    chk_stat("clridle", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0);

    // Reset mid-drain empties the queue and zeroes the head.
    drive(1'b0, 1'b1, 5'd11, 32'h11, 12'h011, 1'b0);
    step();
    drive(1'b0, 1'b1, 5'd12, 32'h12, 12'h012, 1'b0);
    step();
    chk_stat("prerst", 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 12'd0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_stat("midrst", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    chk_head("midrst", 5'd0, 32'd0, 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
